// File: rtl/clock_divider_prog_if.sv
// clock_divider_prog_if: divisor load strobe and divided-clock status bundle for clock_divider_prog.
interface clock_divider_prog_if #(
   parameter int W = 8
);
   logic [W-1:0] div_i;
   logic         div_vld_i;
   logic         clk_div_o;
   logic         tick_o;
   logic         div_pend_o;
   logic         err_o;
   modport master (output div_i, div_vld_i, input clk_div_o, tick_o, div_pend_o, err_o);
   modport slave  (input div_i, div_vld_i, output clk_div_o, tick_o, div_pend_o, err_o);
endinterface

// File: rtl/clock_divider_prog.sv
// clock_divider_prog: runtime-programmable integer clock divider, divisor changes land on period boundaries.
// CLKDIV_ODD_DUTY50_EN adds a falling-edge stage that gives odd divisors a 50% duty cycle.
module clock_divider_prog #(
   parameter int TCQ       = 1,
   parameter int W         = 8,
   parameter int C_DIV_RST = 10
) (
   input logic                 clk_i,
   input logic                 rst_i,
   clock_divider_prog_if.slave bus
);
   logic [W-1:0] cnt, div_q, pend_q;
   logic         pend_vld, clk_div_q, tick_q, err_q, wrap, legal;
   if (C_DIV_RST < 2 || C_DIV_RST > 2**W - 1 || TCQ < 0) begin : g_bad_param
      $error("clock_divider_prog: illegal parameter value");
   end
   assign wrap  = cnt == div_q - 1'b1;
   assign legal = bus.div_vld_i && bus.div_i > W'(1);
   // A load on the boundary cycle goes straight into the active divisor.
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) begin
         cnt       <= '0;
         div_q     <= W'(C_DIV_RST);
         pend_q    <= '0;
         pend_vld  <= 1'b0;
         clk_div_q <= 1'b0;
         tick_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         cnt       <= wrap ? '0 : cnt + 1'b1;
         clk_div_q <= cnt < (div_q >> 1);
         tick_q    <= cnt == '0;
         err_q     <= bus.div_vld_i && !legal;
         if (wrap) begin
            div_q    <= legal ? bus.div_i : pend_vld ? pend_q : div_q;
            pend_vld <= 1'b0;
         end else if (legal) begin
            pend_q   <= bus.div_i;
            pend_vld <= 1'b1;
         end
      end
`ifdef CLKDIV_ODD_DUTY50_EN
   logic neg_q;
   always_ff @(negedge clk_i or posedge rst_i)
      if (rst_i) neg_q <= 1'b0;
      else neg_q <= clk_div_q;
   // div_q only changes on a boundary, where both terms are already low.
   assign bus.clk_div_o = clk_div_q | (div_q[0] & neg_q);
`else
   assign bus.clk_div_o = clk_div_q;
`endif
   assign bus.tick_o     = tick_q;
   assign bus.div_pend_o = pend_vld;
   assign bus.err_o      = err_q;
endmodule

// File: tb/tb_clock_divider_prog.sv
// tb_clock_divider_prog: directed checks of divider periods, loads, rejects and async reset.
module tb_clock_divider_prog;
`ifdef CLKDIV_ODD_DUTY50_EN
   localparam bit ODD50 = 1'b1;
`else
   localparam bit ODD50 = 1'b0;
`endif
   logic clk = 1'b0;
   logic rst;
   int   n_cmp = 0;
   int   n_bad = 0;
   clock_divider_prog_if #(.W(8)) bus ();
   clock_divider_prog #(.TCQ(1), .W(8), .C_DIV_RST(10)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   // Runs m cycles of a period of n starting at cnt 0, with up to two load strobes (slot -1 = none).
   task automatic per(input int n, input int m, input int la, input int va, input int lb, input int vb);
      logic pa, pb;
      for (int i = 0; i < m; i++) begin
         if (i == la) begin bus.div_vld_i = 1'b1; bus.div_i = 8'(va); end
         if (i == lb) begin bus.div_vld_i = 1'b1; bus.div_i = 8'(vb); end
         @(posedge clk); #2;
         bus.div_vld_i = 1'b0;
         pa = la >= 0 && la < n - 1 && va > 1 && i >= la;
         pb = lb >= 0 && lb < n - 1 && vb > 1 && i >= lb;
         chk($sformatf("n%0d c%0d clk_div", n, i), bus.clk_div_o, (ODD50 && n % 2 == 1) ? i <= n / 2 : i < n / 2);
         chk($sformatf("n%0d c%0d tick", n, i), bus.tick_o, i == 0);
         chk($sformatf("n%0d c%0d pend", n, i), bus.div_pend_o, (pa || pb) && i < n - 1);
         chk($sformatf("n%0d c%0d err", n, i), bus.err_o, (i == la && va < 2) || (i == lb && vb < 2));
         @(negedge clk); #2;
         chk($sformatf("n%0d c%0d clk_div_mid", n, i), bus.clk_div_o, i < n / 2);
      end
   endtask
   initial begin
      rst = 1'b1;
      bus.div_i = '0;
      bus.div_vld_i = 1'b0;
      #3;
      chk("rst clk_div", bus.clk_div_o, 1'b0);
      chk("rst tick", bus.tick_o, 1'b0);
      chk("rst pend", bus.div_pend_o, 1'b0);
      chk("rst err", bus.err_o, 1'b0);
      repeat (2) @(posedge clk);
      #2;
      chk("rst held clk_div", bus.clk_div_o, 1'b0);
      chk("rst held tick", bus.tick_o, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      #2;
      per(10, 10, -1, 0, -1, 0);
      per(10, 10, -1, 0, -1, 0);
      per(10, 10, 3, 1, -1, 0);
      per(10, 10, -1, 0, -1, 0);
      per(10, 10, 2, 7, -1, 0);
      per(7, 7, -1, 0, -1, 0);
      per(7, 7, 1, 4, 3, 6);
      per(6, 6, 5, 2, -1, 0);
      per(2, 2, -1, 0, -1, 0);
      per(2, 2, -1, 0, -1, 0);
      per(2, 2, 1, 10, -1, 0);
      per(10, 3, 1, 5, -1, 0);
      #1;
      rst = 1'b1;
      #1;
      chk("async rst clk_div", bus.clk_div_o, 1'b0);
      chk("async rst tick", bus.tick_o, 1'b0);
      chk("async rst pend", bus.div_pend_o, 1'b0);
      chk("async rst err", bus.err_o, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      #2;
      per(10, 10, -1, 0, -1, 0);
      per(10, 10, -1, 0, -1, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
